// File: rtl/sc_fetch_unit_pkg.sv
// Shared encodings for the fetch stage and the control unit.
// Next-PC source selects, fetch FSM states and the branch-offset helper.
package sc_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JR  = 2'b10,
        PC_JMP = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10
    } fetch_state_e;

    // Word offset of a 16-bit branch immediate, as a byte displacement
    function automatic logic [XLEN-1:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/sc_next_pc.sv
// Combinational next-PC select: sequential, branch, register jump, jump.
// Only the low 26 instruction bits are ever needed for target formation.
module sc_next_pc
    import sc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc4,
    input  logic [25:0] inst_lo,
    input  logic [31:0] ra_data,
    input  logic [1:0]  pcsource,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc4;
        unique case (pcsource)
            PC_SEQ: next_pc = pc4;
            PC_BR:  next_pc = pc4 + br_offset(inst_lo[15:0]);
            PC_JR:  next_pc = ra_data;
            PC_JMP: next_pc = {pc4[31:28], inst_lo, 2'b00};
            default: next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/sc_fetch_unit.sv
// Fetch stage: PC register, one-in-flight fetch FSM against a
// variable-latency instruction memory, and the retired-instruction counter.
module sc_fetch_unit
    import sc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        inst_valid,
    input  logic [1:0]  pcsource,
    input  logic [31:0] ra_data,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        misalign,
    output logic [31:0] instret
);

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic [31:0]  next_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                inst_valid = 1'b1;
                state_nxt  = FETCH;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign imem_addr = pc;
    assign pc4       = pc + 32'd4;
    assign op        = inst[31:26];
    assign func      = inst[5:0];

    sc_next_pc u_next_pc (
        .pc4      (pc4),
        .inst_lo  (inst[25:0]),
        .ra_data  (ra_data),
        .pcsource (pcsource),
        .next_pc  (next_pc)
    );

    // A misaligned jr target is truncated to a word and latched as sticky
    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= RESET_PC;
            inst     <= '0;
            misalign <= 1'b0;
            instret  <= '0;
        end else begin
            if (imem_req && imem_ready) begin
                inst <= imem_rdata;
            end
            if (inst_valid) begin
                pc      <= {next_pc[31:2], 2'b00};
                instret <= instret + 32'd1;
                if (next_pc[1:0] != 2'b00) begin
                    misalign <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sc_fetch_unit.sv
// Randomized bench for sc_fetch_unit with a transaction-level reference
// model and literal expectations for the directed scenarios.
module tb_sc_fetch_unit;
    import sc_fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        inst_valid;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] ra_data = '0;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        misalign;
    logic [31:0] instret;

    sc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .op         (op),
        .func       (func),
        .inst_valid (inst_valid),
        .pcsource   (pcsource),
        .ra_data    (ra_data),
        .pc         (pc),
        .pc4        (pc4),
        .misalign   (misalign),
        .instret    (instret)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_ir;
    logic        m_mis;
    logic [5:0]  last_op;
    logic [31:0] last_pc4;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_common();
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("pc4", pc4, m_pc + 32'd4);
        chk("inst", inst, m_inst);
        chk("op", {26'b0, op}, {26'b0, m_inst[31:26]});
        chk("func", {26'b0, func}, {26'b0, m_inst[5:0]});
        chk("instret", instret, m_ir);
        chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    endtask

    // One instruction: w wait cycles in FETCH, then one EXEC cycle
    task automatic do_instr(input int w, input logic [31:0] word,
                            input logic [1:0] psrc, input logic [31:0] ra);
        logic [31:0] tgt;
        for (int k = 0; k <= w; k++) begin
            @(negedge clock);
            check_common();
            chk("imem_req_fetch", {31'b0, imem_req}, 32'd1);
            chk("inst_valid_fetch", {31'b0, inst_valid}, 32'd0);
            imem_ready = (k == w);
            imem_rdata = (k == w) ? word : $urandom;
            pcsource   = 2'($urandom);
            ra_data    = $urandom;
        end
        @(negedge clock);
        m_inst = word;
        check_common();
        chk("imem_req_exec", {31'b0, imem_req}, 32'd0);
        chk("inst_valid_exec", {31'b0, inst_valid}, 32'd1);
        last_op    = op;
        last_pc4   = pc4;
        imem_ready = 1'($urandom);
        imem_rdata = $urandom;
        pcsource   = psrc;
        ra_data    = ra;
        case (psrc)
            2'b00: tgt = m_pc + 32'd4;
            2'b01: tgt = m_pc + 32'd4 + ({{16{word[15]}}, word[15:0]} << 2);
            2'b10: tgt = ra;
            default: tgt = ((m_pc + 32'd4) & 32'hF000_0000)
                           | ({6'b0, word[25:0]} << 2);
        endcase
        if (tgt % 4 != 0) m_mis = 1'b1;
        m_pc = tgt & ~32'h3;
        m_ir = m_ir + 32'd1;
    endtask

    // Reset for one edge (abandoning any fetch), then a late ready in IDLE
    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        imem_ready = 1'b0;
        @(negedge clock);
        m_pc   = RST_PC;
        m_inst = '0;
        m_ir   = '0;
        m_mis  = 1'b0;
        check_common();
        chk("imem_req_rst", {31'b0, imem_req}, 32'd0);
        chk("inst_valid_rst", {31'b0, inst_valid}, 32'd0);
        reset      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int w;
        logic [1:0] ps;
        logic [31:0] ra;

        do_reset();
        repeat (3) do_instr(0, $urandom, PC_SEQ, 32'h0);
        after_edge();
        chk("lit_instret3", instret, 32'd3);
        chk("lit_pc_seq", pc, 32'h0000_000C);

        do_reset();
        do_instr(3, 32'h2108_0001, PC_SEQ, 32'h0);
        chk("lit_op", {26'b0, last_op}, 32'h8);
        after_edge();
        chk("lit_pc_wait", pc, 32'h0000_0004);

        do_instr(0, $urandom, PC_JR, 32'h0000_0010);
        do_instr(0, 32'h1234_FFFE, PC_BR, $urandom);
        after_edge();
        chk("lit_br_back", pc, 32'h0000_000C);

        do_instr(0, $urandom, PC_JR, 32'h0000_0010);
        do_instr(1, 32'h1000_0003, PC_BR, $urandom);
        after_edge();
        chk("lit_br_fwd", pc, 32'h0000_0020);

        do_instr(0, $urandom, PC_JR, 32'h4000_0000);
        do_instr(2, 32'h0C00_0010, PC_JMP, $urandom);
        chk("lit_jal_pc4", last_pc4, 32'h4000_0004);
        after_edge();
        chk("lit_jal_pc", pc, 32'h4000_0040);

        do_instr(0, $urandom, PC_JR, 32'h0000_0103);
        after_edge();
        chk("lit_jr_pc", pc, 32'h0000_0100);
        chk("lit_misalign", {31'b0, misalign}, 32'd1);
        do_instr(1, $urandom, PC_SEQ, $urandom);
        after_edge();
        chk("lit_misalign_sticky", {31'b0, misalign}, 32'd1);
        chk("lit_pc_after_mis", pc, 32'h0000_0104);

        do_reset();
        chk("lit_instret_rst", instret, 32'd0);
        chk("lit_pc_rst", pc, RST_PC);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            w  = int'($urandom_range(0, 3));
            ps = 2'($urandom);
            ra = $urandom;
            if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
            do_instr(w, $urandom, ps, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sc_fetch_unit.md
Name: sc_fetch_unit

Overview:
- Instruction fetch stage for the single-cycle-style CPU. Holds the PC and requests instruction words from a variable-latency instruction memory.
- Presents the fetched instruction, including op/func, directly to the control unit.
- Computes next PC from the control unit's pcsource. Counts retired instructions.
- One instruction is in flight at a time: fetch, then execute for one cycle, then fetch again.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  byte address of the requested word (= pc).
- imem_ready  input  1  memory returns imem_rdata this cycle; sampled only while imem_req=1.
- imem_rdata  input  32  instruction word.
- inst  output  32  registered instruction.
- op  output  6  inst[31:26].
- func  output  6  inst[5:0].
- inst_valid  output  1  high for exactly one EXEC cycle; datapath commits (wreg/wmem) only when high.
- pcsource  input  2  from control unit: 00 pc+4, 01 branch, 10 jr, 11 j/jal.
- ra_data  input  32  register-file read port A value (jr target).
- pc  output  32  address of the current instruction.
- pc4  output  32  pc+4 (jal link value).
- misalign  output  1  sticky flag; set when a computed target has bits [1:0] != 0.
- instret  output  32  retired-instruction counter.

Behaviour:
- Reset (synchronous, active-high) values: pc=RESET_PC, inst=0, state=IDLE, inst_valid=0, imem_req=0, misalign=0, instret=0.
- Reset asserted in any state, including mid-WAIT, abandons the outstanding request. A late imem_ready is ignored because imem_req=0.
- States:
  - IDLE: imem_req=0. Next state is FETCH unconditionally.
  - FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ready. On imem_ready=1: inst<=imem_rdata, next state EXEC. Otherwise stay in FETCH.
  - EXEC: inst_valid=1, imem_req=0. At the clock edge: pc<=next_pc, instret<=instret+1 (wraps 2^32-1 -> 0), next state FETCH.
- Minimum latency: 2 cycles per instruction (FETCH with immediate ready, then EXEC).
- imem_ready sampled in the same cycle imem_req rises is legal: zero-wait memory.
- op/func are combinational slices of the inst register; they are stable for the whole of EXEC and FETCH.
- pc4 = pc+4, modulo 2^32.
- next_pc by pcsource, evaluated in EXEC only:
  - 00: pc4.
  - 01: pc4 + (sign_extend(inst[15:0]) << 2), modulo 2^32.
  - 10: ra_data.
  - 11: {pc4[31:28], inst[25:0], 2'b00}.
- Alignment: if next_pc[1:0] != 0 (only possible on jr), pc loads {next_pc[31:2],2'b00} and misalign<=1. misalign is cleared only by reset.
- pcsource and ra_data are ignored outside EXEC.

Decomposition:
- Shared package: pcsource encodings (PC_SEQ=2'b00, PC_BR=2'b01, PC_JR=2'b10, PC_JMP=2'b11) and fetch state encodings (IDLE, FETCH, EXEC), shared with the control unit and top level.
- One natural sub-module: sc_next_pc, a purely combinational next-PC mux/adder taking pc4, inst, ra_data and pcsource. The FSM, PC register and counter stay in sc_fetch_unit.

Test Plan:
- Reset release, zero-wait memory, pcsource=00: imem_req low 1 cycle after reset, then imem_addr 0x0, 0x4, 0x8 on alternate cycles; instret=3 after three EXEC cycles.
- imem_ready delayed 3 cycles, inst=0x2108_0001: imem_req/imem_addr=0x0 held 4 cycles; inst_valid pulses once; op=6'h08; pc then 0x4.
- Branch at pc=0x10, inst[15:0]=16'hFFFE, pcsource=01: next pc=0x0C. Then inst[15:0]=16'h0003: next pc=0x10+4+0xC=0x20.
- jal at pc=0x4000_0000, inst=0x0C00_0010, pcsource=11: pc4=0x4000_0004 during EXEC; next pc=0x4000_0040.
- jr with ra_data=0x0000_0103, pcsource=10: pc=0x0000_0100, misalign=1 and stays set across later instructions.
- Reset asserted during FETCH with imem_ready low, ready arriving the next cycle: no inst_valid; pc=RESET_PC; instret=0; fetch restarts after one IDLE cycle.
